// File: rtl/prio_arbiter_pkg.sv
// rtl/prio_arbiter_pkg.sv - shared state encoding and mode constants for prio_arbiter
package prio_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/prio_arbiter_if.sv
// rtl/prio_arbiter_if.sv - request/grant bundle between requesters and prio_arbiter
interface prio_arbiter_if #(
  parameter int N = 8
);
  localparam int IDXW = $clog2(N);

  logic [N-1:0]    req;
  logic            en;
  logic            mode;
  logic [N-1:0]    gnt_oh;
  logic [IDXW-1:0] gnt_idx;
  logic            gnt_vld;
  logic            timeout;

  // requester side drives requests and control, observes the grant
  modport master (
    output req, en, mode,
    input  gnt_oh, gnt_idx, gnt_vld, timeout
  );

  // arbiter side
  modport slave (
    input  req, en, mode,
    output gnt_oh, gnt_idx, gnt_vld, timeout
  );

endinterface

// File: rtl/prio_arbiter_pick.sv
// rtl/prio_arbiter_pick.sv - combinational downward-wrapping priority search (prio_pick)
module prio_pick #(
  parameter int N    = 8,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] start,
  input  logic [N-1:0]    mask,
  output logic [IDXW-1:0] win_idx,
  output logic            win_vld
);

  logic [N-1:0] eff;
  int           j;

  assign eff = req & ~mask;

  // walk from start downward, wrapping 0 -> N-1; the first set bit wins
  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(start) - k;
      if (j < 0) j = j + N;
      if (!win_vld && eff[IDXW'(j)]) begin
        win_idx = IDXW'(j);
        win_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_arbiter.sv
// rtl/prio_arbiter.sv - registered N-input fixed/round-robin arbiter; PRIO_ARBITER_TIMEOUT_EN adds forced release
module prio_arbiter
  import prio_arbiter_pkg::*;
#(
  parameter int N        = 8,
  parameter int HOLD_MAX = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  prio_arbiter_if.slave bus
);

  localparam int IDXW = $clog2(N);

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [N-1:0]    oh_q, oh_d;
  logic [IDXW-1:0] rr_q, rr_d;
  logic [IDXW-1:0] ptr_rel;
  logic [IDXW-1:0] start;
  logic [N-1:0]    mask;
  logic [IDXW-1:0] win_idx;
  logic            win_vld;
  logic            hold;
  logic            force_rel;
  logic            arb;

  // current grantee is still asking for the resource
  assign hold    = (state_q == GRANT) && bus.req[idx_q];
  assign ptr_rel = (idx_q == '0) ? IDXW'(N - 1) : idx_q - IDXW'(1);
  assign arb     = !hold || force_rel;

  // a releasing grant searches from the freshly updated pointer
  assign start = (bus.mode == MODE_RR) ? ((state_q == GRANT) ? ptr_rel : rr_q)
                                       : IDXW'(N - 1);
  assign mask  = force_rel ? (N'(1) << idx_q) : '0;

  prio_pick #(.N(N), .IDXW(IDXW)) u_pick (
    .req     (bus.req),
    .start   (start),
    .mask    (mask),
    .win_idx (win_idx),
    .win_vld (win_vld)
  );

`ifdef PRIO_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q;

  assign force_rel   = hold && (cnt_q == CW'(HOLD_MAX - 1));
  assign bus.timeout = to_q;

  // hold counter restarts on each new grant and advances while granted
  always_comb begin
    cnt_d = cnt_q;
    if (arb && bus.en && win_vld) cnt_d = '0;
    else if (state_q == GRANT)    cnt_d = cnt_q + CW'(1);
  end
`else
  wire unused_hold_max = |HOLD_MAX;

  assign force_rel   = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  // next grant: keep the holder, otherwise arbitrate (release or idle)
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    oh_d    = oh_q;
    rr_d    = rr_q;
    if ((state_q == GRANT) && arb) rr_d = ptr_rel;
    if (arb) begin
      if (bus.en && win_vld) begin
        state_d = GRANT;
        idx_d   = win_idx;
        oh_d    = N'(1) << win_idx;
      end else begin
        state_d = IDLE;
        idx_d   = '0;
        oh_d    = '0;
      end
    end
  end

  // state and registered grant outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      oh_q    <= '0;
      rr_q    <= IDXW'(N - 1);
`ifdef PRIO_ARBITER_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      oh_q    <= oh_d;
      rr_q    <= rr_d;
`ifdef PRIO_ARBITER_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= force_rel;
`endif
    end
  end

  assign bus.gnt_vld = (state_q == GRANT);
  assign bus.gnt_idx = idx_q;
  assign bus.gnt_oh  = oh_q;

endmodule

// File: tb/tb_prio_arbiter.sv
// tb/tb_prio_arbiter.sv - self-checking bench for prio_arbiter against a behavioural model
module tb_prio_arbiter;

  localparam int N  = 8;
  localparam int HM = 4;
`ifdef PRIO_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prio_arbiter_if #(.N(N)) bus ();

  prio_arbiter #(.N(N), .HOLD_MAX(HM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // reference state: grant flag, grantee, rotation pointer, cycles held so far
  int m_vld  = 0;
  int m_idx  = 0;
  int m_ptr  = N - 1;
  int m_hold = 0;
  int m_to   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int from, input int excl);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (from - k + N) % N;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  task automatic model_step(input logic rn, input logic [N-1:0] r, input logic e, input logic md);
    int decide;
    int excl;
    int w;
    decide = 0;
    excl   = -1;
    m_to   = 0;
    if (!rn) begin
      m_vld = 0; m_idx = 0; m_ptr = N - 1; m_hold = 0;
      return;
    end
    if (m_vld == 0) begin
      decide = 1;
    end else if (!r[m_idx]) begin
      m_ptr  = (m_idx + N - 1) % N;
      decide = 1;
    end else if (TO_EN && m_hold == HM) begin
      m_to   = 1;
      excl   = m_idx;
      m_ptr  = (m_idx + N - 1) % N;
      decide = 1;
    end else begin
      m_hold++;
    end
    if (decide != 0) begin
      w = e ? pick(r, md ? m_ptr : N - 1, excl) : -1;
      if (w >= 0) begin
        m_vld = 1; m_idx = w; m_hold = 1;
      end else begin
        m_vld = 0; m_idx = 0;
      end
    end
  endtask

  task automatic cyc(input logic [N-1:0] r, input logic e, input logic md);
    bus.req  = r;
    bus.en   = e;
    bus.mode = md;
    @(posedge clk);
    model_step(rst_n, r, e, md);
    @(negedge clk);
    chk("vld", bus.gnt_vld, m_vld);
    chk("idx", bus.gnt_idx, m_idx);
    chk("oh", bus.gnt_oh, m_vld != 0 ? (32'd1 << m_idx) : 32'd0);
    chk("timeout", bus.timeout, m_to);
  endtask

  int seq_rr [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
  int seq_fx [6] = '{7, 6, 7, 6, 7, 6};

  initial begin
    logic [N-1:0] r;
    logic         e;
    logic         md;
    int           prev;

    bus.req = '0; bus.en = 1'b0; bus.mode = 1'b0;
    @(negedge clk);

    // 1: reset with full request
    rst_n = 1'b0;
    cyc(8'hFF, 1'b1, 1'b0);
    cyc(8'hFF, 1'b1, 1'b0);
    chk("rst_vld", bus.gnt_vld, 0);
    chk("rst_oh", bus.gnt_oh, 0);
    chk("rst_idx", bus.gnt_idx, 0);
    rst_n = 1'b1;
    cyc(8'hFF, 1'b1, 1'b0);
    chk("first_idx", bus.gnt_idx, 7);
    cyc(8'h00, 1'b1, 1'b0);

    // 2: fixed priority, hold, back-to-back, idle
    cyc(8'b00011000, 1'b1, 1'b0);
    chk("fx_oh", bus.gnt_oh, 8'b00010000);
    chk("fx_idx", bus.gnt_idx, 4);
    cyc(8'b00011000, 1'b1, 1'b0);
    chk("fx_hold", bus.gnt_idx, 4);
    cyc(8'b00001000, 1'b1, 1'b0);
    chk("fx_b2b", bus.gnt_idx, 3);
    chk("fx_b2b_vld", bus.gnt_vld, 1);
    cyc(8'h00, 1'b1, 1'b0);
    chk("fx_idle", bus.gnt_vld, 0);

    // 3: round-robin rotation, then fixed ping-pong
    rst_n = 1'b0; cyc(8'h00, 1'b1, 1'b1); rst_n = 1'b1;
    cyc(8'hFF, 1'b1, 1'b1);
    chk("rr_first", bus.gnt_idx, 7);
    prev = 7;
    for (int i = 1; i < 9; i++) begin
      cyc(8'hFF & ~(8'h01 << prev), 1'b1, 1'b1);
      chk("rr_seq", bus.gnt_idx, seq_rr[i]);
      prev = seq_rr[i];
    end
    cyc(8'h00, 1'b1, 1'b0);
    cyc(8'hFF, 1'b1, 1'b0);
    chk("fx_first", bus.gnt_idx, 7);
    prev = 7;
    for (int i = 1; i < 6; i++) begin
      cyc(8'hFF & ~(8'h01 << prev), 1'b1, 1'b0);
      chk("fx_seq", bus.gnt_idx, seq_fx[i]);
      prev = seq_fx[i];
    end
    cyc(8'h00, 1'b1, 1'b0);

    // 4: enable gating
    for (int i = 0; i < 5; i++) begin
      cyc(8'h01, 1'b0, 1'b0);
      chk("en_block", bus.gnt_vld, 0);
    end
    cyc(8'h01, 1'b1, 1'b0);
    chk("en_grant", bus.gnt_idx, 0);
    chk("en_grant_vld", bus.gnt_vld, 1);
    cyc(8'h00, 1'b1, 1'b0);
    chk("en_idle", bus.gnt_vld, 0);

    // 5: reset mid-grant restores the rotation pointer
    cyc(8'h20, 1'b1, 1'b1);
    chk("mid_idx", bus.gnt_idx, 5);
    rst_n = 1'b0;
    cyc(8'h20, 1'b1, 1'b1);
    chk("mid_rst_vld", bus.gnt_vld, 0);
    chk("mid_rst_oh", bus.gnt_oh, 0);
    rst_n = 1'b1;
    cyc(8'hFF, 1'b1, 1'b1);
    chk("mid_rr_first", bus.gnt_idx, 7);
    cyc(8'h00, 1'b1, 1'b0);

    // 6: constant contention between 7 and 0
    cyc(8'h81, 1'b1, 1'b0);
    chk("to_first", bus.gnt_idx, 7);
    if (TO_EN) begin
      for (int i = 0; i < 3; i++) cyc(8'h81, 1'b1, 1'b0);
      chk("to_held7", bus.gnt_idx, 7);
      cyc(8'h81, 1'b1, 1'b0);
      chk("to_pulse", bus.timeout, 1);
      chk("to_swap0", bus.gnt_idx, 0);
      for (int i = 0; i < 3; i++) cyc(8'h81, 1'b1, 1'b0);
      chk("to_pulse_off", bus.timeout, 0);
      cyc(8'h81, 1'b1, 1'b0);
      chk("to_swap7", bus.gnt_idx, 7);
    end else begin
      for (int i = 0; i < 100; i++) begin
        cyc(8'h81, 1'b1, 1'b0);
        chk("hold_idx", bus.gnt_idx, 7);
        chk("hold_to", bus.timeout, 0);
      end
    end
    cyc(8'h00, 1'b1, 1'b0);

    // random traffic with sticky requests, occasional reset and mode flips
    r  = '0;
    md = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 9) < 3) r = N'($urandom);
      e = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 39) == 0) md = ~md;
      cyc(r, e, md);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
